// File: rtl/busy_table_if.sv
// busy_table_if: bundle types plus rename/issue/writeback/redirect port bundle for busy_table
package busy_table_pkg;
  typedef struct packed {
    logic [15:0] opid;
    logic [15:0] prda;
  } exe_bundle_t;
  typedef struct packed {
    logic [15:0] opid;
    logic [15:0] topid;
  } red_bundle_t;
endpackage

interface busy_table_if import busy_table_pkg::*; #(
  parameter int rwd = 2,
  parameter int iwd = 2,
  parameter int prsz = 64
);
  logic [rwd-1:0][15:0] alloc_opid;
  logic [rwd-1:0][15:0] alloc_prda;
  logic [rwd-1:0][1:0][15:0] query_prsa;
  logic [rwd-1:0][1:0] busy_resp;
  exe_bundle_t [iwd-1:0] exe_bundle;
  red_bundle_t red_bundle;
  logic [$clog2(prsz):0] busy_cnt;
  modport master(output alloc_opid, alloc_prda, query_prsa, exe_bundle, red_bundle, input busy_resp, busy_cnt);
  modport slave(input alloc_opid, alloc_prda, query_prsa, exe_bundle, red_bundle, output busy_resp, busy_cnt);
endinterface

// File: rtl/busy_table.sv
// busy_table: physical-register busy bits set by rename, cleared by wakeup/redirect squash; BUSY_FWD_EN adds wakeup bypass and busy_cnt
module busy_table import busy_table_pkg::*; #(
  parameter int rwd = 2,
  parameter int iwd = 2,
  parameter int opsz = 64,
  parameter int prsz = 64
) (
  input logic clk,
  input logic rst,
  busy_table_if.slave bt
);
  localparam int aw = $clog2(prsz);
  localparam int ow = $clog2(opsz);
  logic [prsz-1:0] busy, busy_n, woke, avail;
  logic [ow:0] opid_q [prsz];
  logic [ow:0] opid_n [prsz];
  logic red_v;
  logic [ow-1:0] top, red_dist;
  logic unused_ok;
  assign unused_ok = ^{bt.alloc_opid, bt.alloc_prda, bt.query_prsa, bt.exe_bundle, bt.red_bundle};
  assign red_v = bt.red_bundle.opid[15];
  assign top = bt.red_bundle.topid[ow-1:0];
  assign red_dist = bt.red_bundle.opid[ow-1:0] - top + ow'(1);
  always_comb begin
    woke = '0;
    for (int j = 0; j < iwd; j++)
      if (bt.exe_bundle[j].opid[15]) woke[bt.exe_bundle[j].prda[aw-1:0]] = 1'b1;
  end
  always_comb begin
    busy_n = busy & ~woke;
    opid_n = opid_q;
    for (int r = 0; r < prsz; r++)
      if (red_v && opid_q[r][ow] && ow'(opid_q[r][ow-1:0] - top) >= red_dist) busy_n[r] = 1'b0;
    for (int i = 0; i < rwd; i++)
      if (!red_v && bt.alloc_opid[i][15] && |bt.alloc_prda[i][aw-1:0]) begin
        busy_n[bt.alloc_prda[i][aw-1:0]] = 1'b1;
        opid_n[bt.alloc_prda[i][aw-1:0]] = {1'b1, bt.alloc_opid[i][ow-1:0]};
      end
  end
  always_ff @(posedge clk)
    if (rst) begin
      busy <= '0;
      for (int r = 0; r < prsz; r++) opid_q[r] <= '0;
    end else begin
      busy <= busy_n;
      opid_q <= opid_n;
    end
`ifdef BUSY_FWD_EN
  logic [aw:0] cnt_n, cnt_q;
  assign avail = busy & ~woke;
  always_comb begin
    cnt_n = '0;
    for (int r = 0; r < prsz; r++) cnt_n = cnt_n + (aw+1)'(busy_n[r]);
  end
  always_ff @(posedge clk) cnt_q <= rst ? '0 : cnt_n;
  assign bt.busy_cnt = cnt_q;
`else
  assign avail = busy;
  assign bt.busy_cnt = '0;
`endif
  function automatic logic query(input logic [aw-1:0] r, input int i, input logic [prsz-1:0] b,
                                 input logic [rwd-1:0][15:0] ao, input logic [rwd-1:0][15:0] ap);
    logic v;
    v = b[r];
    for (int j = 0; j < i; j++)
      if (ao[j][15] && ap[j][aw-1:0] == r) v = 1'b1;
    return v && |r;
  endfunction
  always_comb begin
    bt.busy_resp = '0;
    for (int i = 0; i < rwd; i++)
      for (int k = 0; k < 2; k++)
        bt.busy_resp[i][k] = query(bt.query_prsa[i][k][aw-1:0], i, avail, bt.alloc_opid, bt.alloc_prda);
  end
endmodule

// File: tb/tb_busy_table.sv
// tb_busy_table: directed vector table plus randomized run against an array-based busy model
module tb_busy_table;
  import busy_table_pkg::*;
  localparam int rwd = 2;
  localparam int iwd = 2;
  localparam int opsz = 64;
  localparam int prsz = 64;
`ifdef BUSY_FWD_EN
  localparam bit fwd = 1'b1;
`else
  localparam bit fwd = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  busy_table_if #(.rwd(rwd), .iwd(iwd), .prsz(prsz)) bif();
  busy_table #(.rwd(rwd), .iwd(iwd), .opsz(opsz), .prsz(prsz)) dut(.clk(clk), .rst(rst), .bt(bif));
  int checks = 0;
  int failures = 0;
  bit rs;
  logic [15:0] ao [rwd];
  logic [15:0] ap [rwd];
  logic [15:0] q [rwd][2];
  logic [15:0] eo [iwd];
  logic [15:0] ep [iwd];
  logic [15:0] ro, rt;
  int mb [prsz];
  logic [15:0] mo [prsz];
  typedef struct {
    string name;
    bit rst;
    bit chk;
    logic [15:0] ao0, ap0, ao1, ap1;
    logic [15:0] q00, q01, q10, q11;
    logic [15:0] eo, ep, ro, rt;
    logic [3:0] exp;
    int cnt;
  } vec_t;
  vec_t vecs [19];
  function automatic vec_t mk(string n, bit r, bit c, logic [15:0] a0, p0, a1, p1, s00, s01, s10, s11,
                              logic [15:0] e, w, o, t, logic [3:0] x, int cn);
    vec_t v;
    v.name = n; v.rst = r; v.chk = c;
    v.ao0 = a0; v.ap0 = p0; v.ao1 = a1; v.ap1 = p1;
    v.q00 = s00; v.q01 = s01; v.q10 = s10; v.q11 = s11;
    v.eo = e; v.ep = w; v.ro = o; v.rt = t; v.exp = x; v.cnt = cn;
    return v;
  endfunction
  task automatic clear_inputs();
    rs = 1'b0; ro = '0; rt = '0;
    for (int i = 0; i < rwd; i++) begin
      ao[i] = '0; ap[i] = '0; q[i][0] = '0; q[i][1] = '0;
    end
    for (int j = 0; j < iwd; j++) begin
      eo[j] = '0; ep[j] = '0;
    end
  endtask
  task automatic apply();
    rst = rs;
    for (int i = 0; i < rwd; i++) begin
      bif.alloc_opid[i] = ao[i];
      bif.alloc_prda[i] = ap[i];
      bif.query_prsa[i][0] = q[i][0];
      bif.query_prsa[i][1] = q[i][1];
    end
    for (int j = 0; j < iwd; j++) begin
      bif.exe_bundle[j].opid = eo[j];
      bif.exe_bundle[j].prda = ep[j];
    end
    bif.red_bundle.opid = ro;
    bif.red_bundle.topid = rt;
  endtask
  task automatic check(input string nm, input logic [3:0] er, input int ec);
    checks++;
    if (bif.busy_resp !== er) begin
      failures++;
      $display("FAIL %s busy_resp=%b expected %b", nm, bif.busy_resp, er);
    end
    checks++;
    if (int'(bif.busy_cnt) !== ec) begin
      failures++;
      $display("FAIL %s busy_cnt=%0d expected %0d", nm, bif.busy_cnt, ec);
    end
  endtask
  function automatic bit m_sq(logic [15:0] o);
    int d = (int'(o % opsz) - int'(rt % opsz) + opsz) % opsz;
    int w = ((int'(ro % opsz) - int'(rt % opsz) + opsz) % opsz + 1) % opsz;
    return ro[15] && o[15] && d >= w;
  endfunction
  function automatic bit m_resp(int i, int r);
    if (r == 0) return 1'b0;
    for (int j = 0; j < i; j++)
      if (ao[j][15] && int'(ap[j] % prsz) == r) return 1'b1;
    if (fwd)
      for (int j = 0; j < iwd; j++)
        if (eo[j][15] && int'(ep[j] % prsz) == r) return 1'b0;
    return mb[r] != 0;
  endfunction
  function automatic int m_cnt();
    int c = 0;
    for (int r = 0; r < prsz; r++) c += mb[r];
    return fwd ? c : 0;
  endfunction
  task automatic m_step();
    int nb [prsz];
    logic [15:0] no [prsz];
    nb = mb;
    no = mo;
    if (rs) begin
      for (int r = 0; r < prsz; r++) begin
        nb[r] = 0; no[r] = '0;
      end
    end else begin
      for (int j = 0; j < iwd; j++)
        if (eo[j][15]) nb[ep[j] % prsz] = 0;
      for (int r = 0; r < prsz; r++)
        if (m_sq(mo[r])) nb[r] = 0;
      if (!ro[15])
        for (int i = 0; i < rwd; i++)
          if (ao[i][15] && (ap[i] % prsz) != 0) begin
            nb[ap[i] % prsz] = 1; no[ap[i] % prsz] = ao[i];
          end
    end
    mb = nb;
    mo = no;
  endtask
  function automatic logic [15:0] rnd_reg();
    return ($urandom_range(0, 7) == 0) ? 16'($urandom) : 16'($urandom_range(0, 15));
  endfunction
  initial begin
    int nxt;
    logic [3:0] er;
    clear_inputs();
    rs = 1'b1;
    apply();
    vecs[0]  = mk("reset",        1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'b0000, 0);
    vecs[1]  = mk("rst_query",    0, 1, 0, 0, 0, 0, 5, 0, 0, 0, 0, 0, 0, 0, 4'b0000, 0);
    vecs[2]  = mk("alloc5",       0, 1, 16'h8003, 5, 0, 0, 5, 0, 0, 0, 0, 0, 0, 0, 4'b0000, 0);
    vecs[3]  = mk("query5",       0, 1, 0, 0, 0, 0, 5, 0, 0, 0, 0, 0, 0, 0, 4'b0001, 1);
    vecs[4]  = mk("intra_group",  0, 1, 16'h8004, 7, 0, 0, 7, 0, 7, 9, 0, 0, 0, 0, 4'b0100, 1);
    vecs[5]  = mk("alloc12",      0, 1, 16'h8005, 12, 0, 0, 7, 0, 0, 0, 0, 0, 0, 0, 4'b0001, 2);
    vecs[6]  = mk("wake12",       0, 1, 0, 0, 0, 0, 12, 0, 0, 0, 16'h8005, 12, 0, 0, fwd ? 4'b0000 : 4'b0001, 3);
    vecs[7]  = mk("woke12",       0, 1, 0, 0, 0, 0, 12, 0, 0, 0, 0, 0, 0, 0, 4'b0000, 2);
    vecs[8]  = mk("wrap_alloc_a", 0, 1, 16'h803E, 40, 16'h803F, 41, 0, 0, 0, 0, 0, 0, 0, 0, 4'b0000, 2);
    vecs[9]  = mk("wrap_alloc_b", 0, 1, 16'h8000, 42, 16'h8001, 43, 40, 41, 0, 0, 0, 0, 0, 0, 4'b0011, 4);
    vecs[10] = mk("redirect",     0, 1, 16'h8002, 20, 0, 0, 42, 43, 40, 0, 0, 0, 16'h803F, 16'h003C, 4'b0111, 6);
    vecs[11] = mk("squashed",     0, 1, 0, 0, 0, 0, 42, 43, 40, 20, 0, 0, 0, 0, 4'b0100, 2);
    vecs[12] = mk("kept",         0, 1, 0, 0, 0, 0, 40, 41, 5, 7, 0, 0, 0, 0, 4'b0011, 2);
    vecs[13] = mk("wake_alloc30", 0, 1, 16'h8011, 30, 0, 0, 30, 0, 0, 0, 16'h8010, 30, 0, 0, 4'b0000, 2);
    vecs[14] = mk("reset30",      1, 1, 0, 0, 0, 0, 30, 0, 0, 0, 0, 0, 0, 0, 4'b0001, 3);
    vecs[15] = mk("after_reset",  0, 1, 0, 0, 0, 0, 30, 0, 0, 0, 0, 0, 0, 0, 4'b0000, 0);
    vecs[16] = mk("alloc50",      0, 1, 16'h8005, 50, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'b0000, 0);
    vecs[17] = mk("flush_wake50", 0, 1, 0, 0, 0, 0, 50, 0, 0, 0, 16'h8005, 50, 16'h8001, 16'h0000, fwd ? 4'b0000 : 4'b0001, 1);
    vecs[18] = mk("cleared50",    0, 1, 0, 0, 0, 0, 50, 0, 0, 0, 0, 0, 0, 0, 4'b0000, 0);
    foreach (vecs[n]) begin
      @(negedge clk);
      clear_inputs();
      rs = vecs[n].rst;
      ao[0] = vecs[n].ao0; ap[0] = vecs[n].ap0; ao[1] = vecs[n].ao1; ap[1] = vecs[n].ap1;
      q[0][0] = vecs[n].q00; q[0][1] = vecs[n].q01; q[1][0] = vecs[n].q10; q[1][1] = vecs[n].q11;
      eo[1] = vecs[n].eo; ep[1] = vecs[n].ep; ro = vecs[n].ro; rt = vecs[n].rt;
      apply();
      #1;
      if (vecs[n].chk) check(vecs[n].name, vecs[n].exp, fwd ? vecs[n].cnt : 0);
    end
    @(negedge clk);
    clear_inputs();
    rs = 1'b1;
    apply();
    m_step();
    nxt = 0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      clear_inputs();
      rs = ($urandom_range(0, 299) == 0);
      for (int i = 0; i < rwd; i++) begin
        ao[i] = {($urandom_range(0, 3) != 0), 9'($urandom), 6'(nxt)};
        nxt = (nxt + 1) % opsz;
        ap[i] = rnd_reg();
        q[i][0] = rnd_reg();
        q[i][1] = rnd_reg();
      end
      for (int j = 0; j < iwd; j++) begin
        eo[j] = {($urandom_range(0, 1) == 1), 15'($urandom)};
        ep[j] = rnd_reg();
      end
      rt = 16'($urandom);
      ro = ($urandom_range(0, 15) == 0) ? {1'b1, 9'($urandom), 6'((rt % opsz) + $urandom_range(0, 63))}
                                        : {1'b0, 15'($urandom)};
      apply();
      #1;
      for (int i = 0; i < rwd; i++)
        for (int k = 0; k < 2; k++) er[i*2+k] = m_resp(i, int'(q[i][k] % prsz));
      check("random", er, m_cnt());
      m_step();
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/busy_table.md
# busy_table

Physical-register busy table for the out-of-order core. It sits between rename and issue and tracks which physical registers still wait for a producer. Rename allocates destinations, which marks them busy, and execution writeback wakes them, which clears them. The block answers per-source busy queries for the rename group that is entering the issue queue. On a pipeline redirect it clears the busy bits owned by squashed producers, so that no freed register stays busy forever.

## Interface
Parameters:
- `rwd`, default 2: rename width, i.e. the number of allocation and query slots per cycle.
- `iwd`, default 2: issue/writeback width, i.e. the number of wakeup slots.
- `opsz`, default 64: operation ID window size, a power of two.
- `prsz`, default 64: number of physical registers, a power of two.

Ports:
- `clk`  input  1  clock.
- `rst`  input  1  reset, synchronous, active-high.
- `alloc_opid`  input  rwd×16  producer opid per slot. Bit 15 means the slot is valid.
- `alloc_prda`  input  rwd×16  destination physical register. A value of 0 means no destination.
- `query_prsa`  input  rwd×2×16  two source physical registers per slot.
- `busy_resp`  output  rwd×2  busy bit per queried source.
- `exe_bundle`  input  exe_bundle_t×iwd  wakeup. Only `.opid[15]` and `.prda` are used.
- `red_bundle`  input  red_bundle_t  redirect. Uses `.opid` (bit 15 means valid) and `.topid`.
- `busy_cnt`  output  $clog2(prsz)+1  number of busy registers (see Configuration).

## Operation
State:
- `bt_busy[prsz]`: one busy bit per physical register.
- `bt_opid[prsz][15:0]`: the opid of the last producer allocated to each register.

Only the low `$clog2(prsz)` bits of register addresses index the table. Register 0 is never busy. Writes to it are ignored and queries of it return 0.

Squash test, which determines whether a stored opid o is squashed by the current redirect:
- All arithmetic is in `$clog2(opsz)` bits, modulo opsz.
- o is squashed when `red_bundle.opid[15]` is set, `o[15]` is set, and `(o - topid) >= (red.opid - topid) + 1`.

Per-cycle register update, applied in this priority order (a later step wins over an earlier one):
1. Wakeup: for each valid `exe_bundle[j]`, clear `bt_busy[prda]`.
2. Flush: if the redirect is valid, clear every `bt_busy[r]` where `bt_opid[r]` is squashed.
3. Allocate: for each valid slot with `alloc_prda != 0`, set `bt_busy[prda]` and write `bt_opid[prda]`.
   - This step applies only when the redirect is invalid. Allocations presented in a redirect cycle are dropped.
   - If two slots name the same prda, the higher slot wins.

Query response (combinational), for slot i and source k, reading register r = `query_prsa[i][k]`:
- The base value is `bt_busy[r]`.
- With `BUSY_FWD_EN` defined, any valid wakeup in the same cycle whose prda equals r forces the base to 0.
- The response is forced to 1 when a lower slot j < i in the same group validly allocates prda r. This intra-group dependency wins over the wakeup bypass.
- The response is forced to 0 when r is 0.
- Queries are answered regardless of redirect. The consumer discards them.

## Timing
- Reset: all `bt_busy` bits are 0, all `bt_opid` entries are 0, and `busy_cnt` is 0. Therefore `busy_resp` is 0 for every query in the cycle after reset, except for intra-group hits.
- Allocation in cycle t: a query in cycle t+1 sees busy=1. A query in cycle t sees it only through the intra-group rule.
- Wakeup in cycle t:
  - The table bit clears at the t+1 edge.
  - The query in cycle t returns 0 only with `BUSY_FWD_EN` defined.
- Redirect in cycle t: squashed bits read 0 from t+1. Non-squashed bits are unchanged.
- Wakeup and allocation to the same register in the same cycle: the register ends up busy.
- Flush and wakeup to the same register in the same cycle: the register ends up not busy.
- opid wrap-around is handled only through the modulo squash test. The implementation must never use absolute comparison of opids.
- Reset asserted mid-operation overrides all updates in that cycle.

## Configuration
`BUSY_FWD_EN` controls the same-cycle wakeup bypass into `busy_resp` and the `busy_cnt` population counter.
- Defined:
  - The wakeup bypass into `busy_resp` is active. It is required when the issue queue does not re-check wakeups for entries written in the same cycle.
  - `busy_cnt` is a registered population count of `bt_busy`, updated one cycle after each change.
- Undefined:
  - The bypass is removed, and `busy_resp` reflects registered state plus intra-group hits only.
  - `busy_cnt` is tied to 0.

## Test plan
- Reset, then query registers 5 and 0 in slot 0: `busy_resp` is 00. Next cycle, allocate prda=5 with opid 0x8003: a query of 5 at t+1 returns 1 and `busy_cnt` reads 1.
- In a single cycle, slot 0 allocates prda=7 and slot 1 queries prsa={7,9} with 9 idle: slot 1 response is {0,1}, i.e. source 0 is busy and source 1 is not. Slot 0 querying 7 in the same cycle returns 0.
- Register 12 is busy, and a wakeup for prda=12 arrives in cycle t while slot 0 queries 12:
  - With `BUSY_FWD_EN` defined, the response is 0 at t.
  - With `BUSY_FWD_EN` undefined, the response is 1 at t.
  - In both builds the response is 0 at t+1.
- Registers are allocated by opids 0x803E, 0x803F, 0x8000 and 0x8001, across the wrap with opsz=64. A redirect follows with topid=0x3C and opid=0x803F. Registers of 0x8000 and 0x8001 clear, and the other two stay busy.
- A redirect coincides with a valid allocation of prda=20: register 20 stays not busy at t+1.
- Wakeup and allocation both target prda=30 in one cycle, and reset is asserted on the next cycle: register 30 reads busy=1 at t+1 and 0 after reset.
